// File: rtl/spi_reg_bank_if.sv
// spi_reg_bank_if: SPI pin bundle between a controller and the register bank
interface spi_reg_bank_if;
  logic SCLK;
  logic COPI;
  logic nCS;
  logic CIPO;
  logic cipo_oe;
  modport master (output SCLK, output COPI, output nCS, input CIPO, input cipo_oe);
  modport slave (input SCLK, input COPI, input nCS, output CIPO, output cipo_oe);
endinterface

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 peripheral exposing a bank of read/write registers
module spi_reg_bank #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int NUM_REGS = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_reg_bank_if.slave              bus,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [7:0]                 err_count
);
  localparam int CW = $clog2(ADDR_W + DATA_W + 1);
  localparam logic [ADDR_W:0] NR = (ADDR_W + 1)'(NUM_REGS);
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] sclk_s, copi_s, ncs_s;
  logic [CW-1:0] cnt;
  logic [ADDR_W:0] cmd;
  logic [DATA_W-1:0] din, dout, rd_data;
  logic ovr, loaded;
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, rw, addr_ok, commit, bad;
  logic [ADDR_W-1:0] addr;
  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] & sclk_s[2];
  assign ncs_rise = ncs_s[1] & ~ncs_s[2];
  assign ncs_fall = ~ncs_s[1] & ncs_s[2];
  assign rw = cmd[ADDR_W];
  assign addr = cmd[ADDR_W-1:0];
  assign addr_ok = {1'b0, addr} < NR;
  assign commit = ncs_rise && state_q == DONE && rw && !ovr && addr_ok;
  assign bad = ncs_rise && (state_q == CMD || state_q == DATA ||
               (state_q == DONE && (ovr || (rw && !addr_ok))));
  assign bus.CIPO = (state_q == DATA || state_q == DONE) && dout[DATA_W-1];
  assign bus.cipo_oe = state_q != IDLE;
  // two-flop synchronisers plus a history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= '0;
      copi_s <= '0;
      ncs_s  <= '0;
    end else begin
      sclk_s <= {sclk_s[1:0], bus.SCLK};
      copi_s <= {copi_s[1:0], bus.COPI};
      ncs_s  <= {ncs_s[1:0], bus.nCS};
    end
  end
  // frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // frame sequencing: chip-select edges dominate, SCLK rises advance phases
  always_comb begin
    state_d = state_q;
    if (ncs_rise) state_d = IDLE;
    else if (ncs_fall) state_d = CMD;
    else if (sclk_rise)
      state_d = (state_q == CMD && cnt == CW'(ADDR_W)) ? DATA :
                (state_q == DATA && cnt == CW'(DATA_W - 1)) ? DONE : state_q;
  end
  // read-back mux; unimplemented addresses read as zero
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (addr == ADDR_W'(k)) rd_data = regs_out[k*DATA_W +: DATA_W];
  end
  // shift-in of command/data, overrun detection and shift-out of read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      cmd    <= '0;
      din    <= '0;
      dout   <= '0;
      ovr    <= 1'b0;
      loaded <= 1'b0;
    end else if (ncs_fall) begin
      cnt    <= '0;
      dout   <= '0;
      ovr    <= 1'b0;
      loaded <= 1'b0;
    end else begin
      if (sclk_rise && state_q == CMD) begin
        cmd <= {cmd[ADDR_W-1:0], copi_s[1]};
        cnt <= (cnt == CW'(ADDR_W)) ? '0 : cnt + CW'(1);
      end
      if (sclk_rise && state_q == DATA) begin
        din <= {din[DATA_W-2:0], copi_s[1]};
        cnt <= cnt + CW'(1);
      end
      if (sclk_rise && state_q == DONE) ovr <= 1'b1;
      if (sclk_fall && state_q == DATA) begin
        dout   <= loaded ? dout << 1 : (rw ? '0 : rd_data);
        loaded <= 1'b1;
      end
    end
  end
  // commit valid writes and count rejected frames when chip select rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_out  <= '0;
      wr_pulse  <= 1'b0;
      wr_addr   <= '0;
      err_count <= '0;
    end else begin
      wr_pulse <= commit;
      if (commit) wr_addr <= addr;
      if (bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
      for (int k = 0; k < NUM_REGS; k++)
        if (commit && addr == ADDR_W'(k)) regs_out[k*DATA_W +: DATA_W] <= din;
    end
  end
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed scenario tests for spi_reg_bank
module tb_spi_reg_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [39:0] regs_out;
  logic wr_pulse;
  logic [6:0] wr_addr;
  logic [7:0] err_count;
  int errors = 0;
  int checks = 0;
  int pulses = 0;
  logic [31:0] rx;
  spi_reg_bank_if bus();
  spi_reg_bank dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .regs_out(regs_out),
    .wr_pulse(wr_pulse),
    .wr_addr(wr_addr),
    .err_count(err_count)
  );
  always #5 clk = ~clk;
  // count commit strobes seen by the bench
  always @(posedge clk) if (wr_pulse === 1'b1) pulses++;
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clock_bit(input logic b, inout logic [31:0] r);
    bus.COPI = b;
    wait_clks(6);
    r = {r[30:0], bus.CIPO};
    bus.SCLK = 1'b1;
    wait_clks(6);
    bus.SCLK = 1'b0;
  endtask
  task automatic spi_frame(input logic [31:0] bits, input int n, output logic [31:0] r);
    r = '0;
    bus.nCS = 1'b0;
    wait_clks(6);
    for (int i = n - 1; i >= 0; i--) clock_bit(bits[i], r);
    wait_clks(6);
    bus.nCS = 1'b1;
    wait_clks(8);
  endtask
  task automatic test_reset;
    bus.SCLK = 1'b0;
    bus.COPI = 1'b0;
    bus.nCS = 1'b1;
    rst_n = 1'b0;
    wait_clks(4);
    checks++; if (regs_out !== 40'h0) begin errors++; $display("FAIL reset_regs got %h want 0", regs_out); end
    checks++; if (err_count !== 8'h0) begin errors++; $display("FAIL reset_err got %h want 0", err_count); end
    checks++; if (bus.CIPO !== 1'b0 || bus.cipo_oe !== 1'b0) begin errors++; $display("FAIL reset_cipo got %b%b want 00", bus.CIPO, bus.cipo_oe); end
    rst_n = 1'b1;
    wait_clks(6);
  endtask
  task automatic test_write;
    pulses = 0;
    spi_frame(32'h825A, 16, rx);
    checks++; if (regs_out !== 40'h00005A0000) begin errors++; $display("FAIL write_regs got %h want 00005a0000", regs_out); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL write_pulses got %0d want 1", pulses); end
    checks++; if (wr_addr !== 7'd2) begin errors++; $display("FAIL write_addr got %0d want 2", wr_addr); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL write_err got %0d want 0", err_count); end
    checks++; if (bus.cipo_oe !== 1'b0) begin errors++; $display("FAIL write_oe_idle got %b want 0", bus.cipo_oe); end
  endtask
  task automatic test_read;
    pulses = 0;
    spi_frame(32'h0200, 16, rx);
    checks++; if (rx[7:0] !== 8'h5A) begin errors++; $display("FAIL read_data got %h want 5a", rx[7:0]); end
    checks++; if (rx[15:8] !== 8'h00) begin errors++; $display("FAIL read_cmd_cipo got %h want 00", rx[15:8]); end
    checks++; if (regs_out !== 40'h00005A0000 || pulses !== 0) begin errors++; $display("FAIL read_nowrite got %h/%0d want 00005a0000/0", regs_out, pulses); end
  endtask
  task automatic test_bad_addr;
    pulses = 0;
    spi_frame(32'h87FF, 16, rx);
    checks++; if (regs_out !== 40'h00005A0000) begin errors++; $display("FAIL badaddr_regs got %h want 00005a0000", regs_out); end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL badaddr_pulses got %0d want 0", pulses); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL badaddr_err got %0d want 1", err_count); end
    checks++; if (wr_addr !== 7'd2) begin errors++; $display("FAIL badaddr_wraddr got %0d want 2", wr_addr); end
  endtask
  task automatic test_short_long;
    pulses = 0;
    spi_frame(32'h80F, 12, rx);
    checks++; if (regs_out !== 40'h00005A0000) begin errors++; $display("FAIL short_regs got %h want 00005a0000", regs_out); end
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL short_err got %0d want 2", err_count); end
    spi_frame(32'h10155, 17, rx);
    checks++; if (regs_out !== 40'h00005A0000 || pulses !== 0) begin errors++; $display("FAIL overrun_nowrite got %h/%0d want 00005a0000/0", regs_out, pulses); end
    checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL overrun_err got %0d want 3", err_count); end
  endtask
  task automatic test_reset_midframe;
    pulses = 0;
    rx = '0;
    bus.nCS = 1'b0;
    wait_clks(6);
    for (int i = 15; i >= 4; i--) clock_bit(1'(32'h8133 >> i), rx);
    rst_n = 1'b0;
    wait_clks(3);
    checks++; if (regs_out !== 40'h0 || wr_addr !== 7'd0 || wr_pulse !== 1'b0) begin errors++; $display("FAIL midrst_outs got %h/%0d/%b want 0/0/0", regs_out, wr_addr, wr_pulse); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL midrst_err got %0d want 0", err_count); end
    checks++; if (bus.CIPO !== 1'b0 || bus.cipo_oe !== 1'b0) begin errors++; $display("FAIL midrst_cipo got %b%b want 00", bus.CIPO, bus.cipo_oe); end
    rst_n = 1'b1;
    wait_clks(2);
    for (int i = 3; i >= 0; i--) clock_bit(1'(32'h8133 >> i), rx);
    wait_clks(6);
    bus.nCS = 1'b1;
    wait_clks(8);
    checks++; if (regs_out !== 40'h0 || pulses !== 0) begin errors++; $display("FAIL midrst_discard got %h/%0d want 0/0", regs_out, pulses); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL midrst_err_after got %0d want 0", err_count); end
    spi_frame(32'h8133, 16, rx);
    checks++; if (regs_out !== 40'h0000003300) begin errors++; $display("FAIL recover_regs got %h want 0000003300", regs_out); end
    checks++; if (wr_addr !== 7'd1 || pulses !== 1) begin errors++; $display("FAIL recover_wr got %0d/%0d want 1/1", wr_addr, pulses); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL recover_err got %0d want 0", err_count); end
  endtask
  task automatic test_saturation;
    for (int i = 0; i < 300; i++) begin
      bus.nCS = 1'b0;
      wait_clks(5);
      bus.nCS = 1'b1;
      wait_clks(5);
      if (i == 253) begin
        checks++; if (err_count !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d want 254", err_count); end
      end
    end
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d want 255", err_count); end
    checks++; if (regs_out !== 40'h0000003300) begin errors++; $display("FAIL sat_regs got %h want 0000003300", regs_out); end
  endtask
  initial begin
    test_reset;
    test_write;
    test_read;
    test_bad_addr;
    test_short_long;
    test_reset_midframe;
    test_saturation;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, width of the address field in the command byte.
REQ-002 SHALL have parameter DATA_W, default 8, width of each register and of the data phase.
REQ-003 SHALL have parameter NUM_REGS, default 5, number of implemented registers (1..2**ADDR_W).
REQ-004 SHALL have port clk  input  1  system clock; sole clock of the block.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port SCLK  input  1  SPI serial clock, asynchronous to clk.
REQ-007 SHALL have port COPI  input  1  SPI controller-out data, asynchronous to clk.
REQ-008 SHALL have port nCS  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-009 SHALL have port CIPO  output  1  SPI peripheral-out data.
REQ-010 SHALL have port cipo_oe  output  1  high while the synchronised nCS is low.
REQ-011 SHALL have port regs_out  output  NUM_REGS*DATA_W  all registers; register k at bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port wr_pulse  output  1  one-clk strobe on every committed write.
REQ-013 SHALL have port wr_addr  output  ADDR_W  address of the last committed write.
REQ-014 SHALL have port err_count  output  8  saturating count of rejected frames.

Function
REQ-015 SHALL synchronise SCLK, COPI and nCS through 2 flops each plus a third history flop for edge detection, all in clk.
REQ-016 SHALL define a frame: synchronised nCS low, then 1 R/W bit (1 = write), ADDR_W address bits, DATA_W data bits, all MSB first, SPI mode 0.
REQ-017 SHALL sample COPI on each detected SCLK rising edge while nCS is low; SCLK edges while nCS is high are ignored.
REQ-018 SHALL use FSM states IDLE, CMD, DATA, DONE; IDLE->CMD on nCS fall; CMD->DATA after 1+ADDR_W rising edges; DATA->DONE after DATA_W further rising edges; any state->IDLE on nCS rise.
REQ-019 SHALL, in DONE, treat any further SCLK rising edge as an overrun and mark the frame invalid.
REQ-020 SHALL commit a write on the clk cycle after the detected nCS rise iff state was DONE, R/W = 1, no overrun, and address < NUM_REGS.
REQ-021 SHALL, on commit, update only the addressed register, pulse wr_pulse for exactly one clk, and load wr_addr.
REQ-022 SHALL, for a read (R/W = 0), load a DATA_W-bit shift-out register with reg[addr] (0 if addr >= NUM_REGS) on the first SCLK falling edge in DATA, driving its MSB on CIPO.
REQ-023 SHALL shift the shift-out register left by one on each subsequent SCLK falling edge in DATA; CIPO SHALL be 0 in IDLE and CMD.
REQ-024 SHALL never modify registers on a read frame.
REQ-025 SHALL increment err_count, saturating at 255, by one per frame that ends (nCS rise) in CMD or DATA, ends with overrun, or is a write to addr >= NUM_REGS; a frame SHALL never increment it more than once.
REQ-026 SHALL treat nCS rise and nCS fall detected in the same clk as impossible; functional correctness requires SCLK high and low times >= 3 clk periods and nCS high time >= 3 clk periods.
REQ-027 SHALL accept back-to-back frames with no added idle time beyond REQ-026.

Reset
REQ-028 SHALL, while rst_n is low, force FSM to IDLE, all registers to 0, regs_out = 0, wr_pulse = 0, wr_addr = 0, err_count = 0, CIPO = 0, cipo_oe = 0, and all synchroniser flops to 0.
REQ-029 SHALL, on reset assertion mid-frame, discard the frame with no register write and no err_count change; first frame after release SHALL start only on a fresh nCS fall.

Verification
REQ-030 SHALL cover: write frame 0x82,0x5A (defaults) -> regs_out[23:16] = 0x5A, one wr_pulse, wr_addr = 2, err_count = 0.
REQ-031 SHALL cover: after REQ-030, read frame 0x02 -> CIPO shifts 0,1,0,1,1,0,1,0; regs_out unchanged.
REQ-032 SHALL cover: write 0x87,0xFF (addr 7 >= NUM_REGS) -> no register change, no wr_pulse, err_count = 1.
REQ-033 SHALL cover: nCS raised after 12 bits of a write to addr 0 -> reg0 unchanged, err_count +1; 17-bit write frame -> no write, err_count +1.
REQ-034 SHALL cover: rst_n pulsed low during data phase of write 0x81,0x33 -> all outputs 0, reg1 = 0, err_count = 0; next valid write succeeds.
REQ-035 SHALL cover: 300 aborted frames -> err_count holds at 255.
